call_stack_engine: RTL and testbench
====================================

# call_stack_engine

Sequential return-address stack engine that executes the CALL/RET control-flow operations, sitting directly downstream of instruction decode and upstream of PC update. It owns a 256-entry × 19-bit stack and an 8-bit descending stack pointer. On CALL it pushes `pc + 1` and redirects to the target address; on RET it pops the return address. Results go to the fetch stage through a valid/ready handshake.

## Interface
- `PC_W`, 19: program-counter and address width.
- `SP_W`, 8: stack-pointer width; stack depth is 2^SP_W = 256.
- `SP_INIT`, 8'hFF: stack-pointer value after reset or flush.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `flush`  in  1  synchronous stack clear; drops any in-flight op.
- `op_valid`  in  1  operation request.
- `op_ready`  out  1  engine can accept an op; equals `(state==IDLE) & ~flush`.
- `op_code`  in  2  00 NOP, 01 CALL, 10 RET, 11 reserved.
- `op_pc`  in  PC_W  PC of the issuing instruction.
- `op_addr`  in  PC_W  CALL target; ignored for other codes.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_pc`  out  PC_W  next PC.
- `res_sp`  out  SP_W  stack pointer after the op.
- `res_err`  out  1  overflow, underflow or reserved opcode.
- `depth`  out  SP_W+1  live entries, 0..256.

## Operation
- Storage: `stack[0:255]`, write-first, synchronous read with a 1-cycle latency. Registers: `sp` (reset `SP_INIT`), `depth` (reset 0), `state`.
- Full-descending stack: a push writes `stack[sp]` and then sets `sp = sp - 1`. A pop reads `stack[sp + 1]` and then sets `sp = sp + 1`. All `sp` arithmetic wraps mod 256.
- Full/empty are decided by `depth` only, never by `sp`, because `sp` returns to 8'hFF after 256 pushes.
- FSM states: IDLE, RET_RD, RESP.
- IDLE, on `op_valid & op_ready`:
  - CALL with `depth < 256`: write `stack[sp] = op_pc + 1` (mod 2^19), `sp -= 1`, `depth += 1`, `res_pc = op_addr`, `res_err = 0`. Go to RESP.
  - CALL with `depth == 256`: no write; `sp` and `depth` unchanged; `res_pc = op_addr`, `res_err = 1`. Go to RESP.
  - RET with `depth > 0`: issue a read of `stack[sp + 1]`. Go to RET_RD.
  - RET with `depth == 0`: no change; `res_pc = op_pc + 1`, `res_err = 1`. Go to RESP.
  - NOP: `res_pc = op_pc + 1`, `res_err = 0`. Go to RESP.
  - Reserved opcode: `res_pc = op_pc + 1`, `res_err = 1`. Go to RESP.
- RET_RD: `res_pc = read data`, `sp += 1`, `depth -= 1`, `res_err = 0`. Go to RESP.
- RESP:
  - `res_valid = 1`; `res_pc`, `res_sp` and `res_err` are held stable.
  - When `res_ready` is high, go to IDLE.
  - `res_sp` always shows the post-op `sp`.
- `flush` (any state):
  - Next cycle: `sp = SP_INIT`, `depth = 0`, `state = IDLE`, `res_valid = 0`.
  - No stack write occurs in a flush cycle, even if `op_valid` is high.
  - Stack contents are not cleared.
- Priority: `rst_n` low > `flush` > operation.

## Timing
- Reset values (sampled on a `clk` edge with `rst_n` low):
  - `state` = IDLE, `sp` = 8'hFF, `depth` = 0.
  - `res_valid` = 0, `res_pc` = 0, `res_sp` = 8'hFF, `res_err` = 0.
  - `op_ready` = 1 once `rst_n` is high and `flush` is low.
- Latency, with the op accepted in cycle N:
  - CALL, NOP, error cases: `res_valid` high in N+1.
  - RET hit: `res_valid` high in N+2.
- Throughput:
  - One op per 2 cycles (CALL) or 3 cycles (RET) when `res_ready` is held high.
  - `op_ready` is low in RET_RD and RESP.
- Backpressure: `res_valid` stays high and the outputs are frozen until `res_ready` is high. No new op is accepted meanwhile.
- A `flush` in the same cycle as a RESP handshake still returns to IDLE. The handshaken result counts as delivered.
- `pc + 1` at `op_pc = 19'h7FFFF` wraps to 0.

## Test plan
- Reset, then CALL `op_pc=0x00100`, `op_addr=0x02000` -> `res_pc=0x02000`, `res_sp=0xFE`, `depth=1`, `res_err=0`, `res_valid` in N+1. Then RET -> `res_pc=0x00101`, `res_sp=0xFF`, `depth=0`, `res_valid` in N+2.
- Nested CALLs from pc 0x10, 0x20, 0x30, then 3 RETs -> returns 0x31, 0x21, 0x11 in LIFO order. `sp` goes 0xFF->0xFC->0xFF.
- 256 CALLs -> `depth=256`, `sp=0xFF`. A 257th CALL -> `res_err=1`, `depth` stays 256, no overwrite (the next RET returns the 256th pushed address).
- RET at `depth=0` with `op_pc=0x7FFFF` -> `res_err=1`, `res_pc=0x00000`, `sp` and `depth` unchanged. Opcode 11 -> `res_err=1`.
- Hold `res_ready` low for 5 cycles after a CALL -> `res_valid` and `res_pc` stay stable and `op_ready=0`; the result completes on the `res_ready` pulse.
- `flush` in RET_RD at `depth=3` -> next cycle IDLE, `depth=0`, `sp=0xFF`, no `res_valid`. Drop `rst_n` mid-RESP -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/call_stack_engine.sv
// Return-address stack engine for CALL/RET: 256-deep full-descending stack,
// one op in flight, result delivered to fetch over a valid/ready handshake.
module call_stack_engine #(
   parameter int unsigned     PC_W    = 19,
   parameter int unsigned     SP_W    = 8,
   parameter logic [SP_W-1:0] SP_INIT = 8'hFF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            op_valid,
   output logic            op_ready,
   input  logic [1:0]      op_code,
   input  logic [PC_W-1:0] op_pc,
   input  logic [PC_W-1:0] op_addr,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [PC_W-1:0] res_pc,
   output logic [SP_W-1:0] res_sp,
   output logic            res_err,
   output logic [SP_W:0]   depth
);

   localparam int unsigned   DEPTH_N    = 1 << SP_W;
   localparam logic [SP_W:0] DEPTH_FULL = {1'b1, {SP_W{1'b0}}};

   typedef enum logic [1:0] {IDLE, RET_RD, RESP} state_t;

   state_t          state_q, state_d;
   logic [SP_W-1:0] sp_q, sp_d;
   logic [SP_W:0]   depth_q, depth_d;
   logic [PC_W-1:0] res_pc_q, res_pc_d;
   logic            res_err_q, res_err_d;

   logic            we, re;
   logic [PC_W-1:0] wdata;
   logic [SP_W-1:0] raddr;
   logic [PC_W-1:0] rd_q;
   logic [PC_W-1:0] stack_mem [DEPTH_N];

   // Storage has no reset; contents deliberately survive flush and reset.
   always_ff @(posedge clk) begin
      if (we && rst_n) stack_mem[sp_q] <= wdata;
      if (re && rst_n) rd_q <= (we && raddr == sp_q) ? wdata : stack_mem[raddr];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sp_q      <= SP_INIT;
         depth_q   <= '0;
         res_pc_q  <= '0;
         res_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sp_q      <= sp_d;
         depth_q   <= depth_d;
         res_pc_q  <= res_pc_d;
         res_err_q <= res_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sp_d      = sp_q;
      depth_d   = depth_q;
      res_pc_d  = res_pc_q;
      res_err_d = res_err_q;
      we        = 1'b0;
      re        = 1'b0;
      wdata     = op_pc + 1'b1;
      raddr     = sp_q + 1'b1;
      if (flush) begin
         state_d = IDLE;
         sp_d    = SP_INIT;
         depth_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (op_valid) begin
                  state_d   = RESP;
                  res_pc_d  = op_pc + 1'b1;
                  res_err_d = 1'b0;
                  case (op_code)
                     2'b01: begin
                        res_pc_d = op_addr;
                        // Fullness comes from depth: sp alone aliases after 256 pushes.
                        if (depth_q == DEPTH_FULL) begin
                           res_err_d = 1'b1;
                        end else begin
                           we      = 1'b1;
                           sp_d    = sp_q - 1'b1;
                           depth_d = depth_q + 1'b1;
                        end
                     end
                     2'b10: begin
                        if (depth_q == '0) begin
                           res_err_d = 1'b1;
                        end else begin
                           re      = 1'b1;
                           state_d = RET_RD;
                        end
                     end
                     2'b11:   res_err_d = 1'b1;
                     default: ;
                  endcase
               end
            end
            RET_RD: begin
               res_pc_d  = rd_q;
               res_err_d = 1'b0;
               sp_d      = sp_q + 1'b1;
               depth_d   = depth_q - 1'b1;
               state_d   = RESP;
            end
            RESP: begin
               if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign op_ready  = (state_q == IDLE) & ~flush;
   assign res_valid = (state_q == RESP);
   assign res_pc    = res_pc_q;
   assign res_sp    = sp_q;
   assign res_err   = res_err_q;
   assign depth     = depth_q;

endmodule

// File: tb/tb_call_stack_engine.sv
// Bench for call_stack_engine: queue-based stack model feeds a scoreboard,
// an independent monitor checks every delivered result and its latency.
module tb_call_stack_engine;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic [1:0]  op_code = 2'b00;
   logic [18:0] op_pc = '0;
   logic [18:0] op_addr = '0;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [18:0] res_pc;
   logic [7:0]  res_sp;
   logic        res_err;
   logic [8:0]  depth;

   call_stack_engine #(.PC_W(19), .SP_W(8), .SP_INIT(8'hFF)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
      .op_pc(op_pc), .op_addr(op_addr),
      .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
      .res_sp(res_sp), .res_err(res_err), .depth(depth)
   );

   typedef struct {
      logic [18:0] pc;
      logic [7:0]  sp;
      logic        err;
      logic [8:0]  dep;
      int          lat;
      int          icyc;
   } exp_t;

   exp_t        sb[$];
   logic [18:0] mstk[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          rmode = 2;

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // res_ready: 0 random, 1 held low, 2 held high; updated away from both edges
   initial forever begin
      @(posedge clk);
      #2;
      case (rmode)
         0:       res_ready = ($urandom_range(0, 3) != 0);
         1:       res_ready = 1'b0;
         default: res_ready = 1'b1;
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Monitor
   initial begin
      bit          seen = 0;
      logic [18:0] cap_pc;
      logic [7:0]  cap_sp;
      logic        cap_err;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (rst_n && res_valid) begin
            if (!seen) begin
               seen    = 1;
               cap_pc  = res_pc;
               cap_sp  = res_sp;
               cap_err = res_err;
               if (sb.size() > 0) chk("latency", 32'(cyc - sb[0].icyc), 32'(sb[0].lat));
            end else begin
               chk("hold_pc", 32'(res_pc), 32'(cap_pc));
               chk("hold_sp", 32'(res_sp), 32'(cap_sp));
               chk("hold_err", 32'(res_err), 32'(cap_err));
            end
            chk("op_ready_busy", 32'(op_ready), 32'd0);
            if (res_ready) begin
               if (sb.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_result: got pc %0h with no result required", res_pc);
               end else begin
                  e = sb.pop_front();
                  chk("res_pc", 32'(res_pc), 32'(e.pc));
                  chk("res_sp", 32'(res_sp), 32'(e.sp));
                  chk("res_err", 32'(res_err), 32'(e.err));
                  chk("depth", 32'(depth), 32'(e.dep));
               end
               seen = 0;
            end
         end else begin
            seen = 0;
         end
      end
   end

   task automatic issue(input logic [1:0] oc, input logic [18:0] pc,
                        input logic [18:0] ad, input bit expect_rsp);
      int          g = 0;
      exp_t        e;
      logic [18:0] p1;
      @(negedge clk);
      while (!op_ready) begin
         @(negedge clk);
         g++;
         if (g > 2000) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_timeout: got op_ready 0 required 1 within 2000 cycles");
            return;
         end
      end
      op_valid = 1'b1;
      op_code  = oc;
      op_pc    = pc;
      op_addr  = ad;
      if (expect_rsp) begin
         p1 = pc + 19'd1;
         e.lat = 1;
         e.err = 1'b0;
         e.pc  = p1;
         case (oc)
            2'b01: begin
               e.pc = ad;
               if (mstk.size() < 256) mstk.push_back(p1);
               else e.err = 1'b1;
            end
            2'b10: begin
               if (mstk.size() > 0) begin
                  e.pc  = mstk.pop_back();
                  e.lat = 2;
               end else e.err = 1'b1;
            end
            2'b11:   e.err = 1'b1;
            default: ;
         endcase
         e.dep  = 9'(mstk.size());
         e.sp   = 8'hFF - 8'(mstk.size());
         e.icyc = cyc;
         sb.push_back(e);
      end
      @(negedge clk);
      op_valid = 1'b0;
      op_code  = 2'b00;
   endtask

   task automatic wait_drain();
      int g = 0;
      while (sb.size() > 0 && g < 3000) begin
         @(negedge clk);
         g++;
      end
      if (sb.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d results pending required 0", sb.size());
         sb.delete();
      end
   endtask

   // Called at a negedge: flush is sampled on the following posedge.
   task automatic flush_now();
      flush = 1'b1;
      #1;
      chk("op_ready_flush", 32'(op_ready), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      mstk.delete();
      #1;
      chk("flush_depth", 32'(depth), 32'd0);
      chk("flush_sp", 32'(res_sp), 32'hFF);
      chk("flush_valid", 32'(res_valid), 32'd0);
      chk("flush_op_ready", 32'(op_ready), 32'd1);
   endtask

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(res_valid), 32'd0);
      chk("rst_pc", 32'(res_pc), 32'd0);
      chk("rst_sp", 32'(res_sp), 32'hFF);
      chk("rst_err", 32'(res_err), 32'd0);
      chk("rst_depth", 32'(depth), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_op_ready", 32'(op_ready), 32'd1);

      // Basic CALL / RET
      issue(2'b01, 19'h00100, 19'h02000, 1);
      issue(2'b10, 19'h02000, 19'h0, 1);
      wait_drain();

      // Nested LIFO
      issue(2'b01, 19'h00010, 19'h01000, 1);
      issue(2'b01, 19'h00020, 19'h02000, 1);
      issue(2'b01, 19'h00030, 19'h03000, 1);
      for (int i = 0; i < 3; i++) issue(2'b10, 19'h05000, 19'h0, 1);
      wait_drain();

      // Overflow: 256 pushes fill the stack, 257th is refused
      for (int i = 0; i < 256; i++) issue(2'b01, 19'($urandom), 19'($urandom), 1);
      wait_drain();
      chk("full_depth", 32'(depth), 32'd256);
      chk("full_sp", 32'(res_sp), 32'hFF);
      issue(2'b01, 19'h12345, 19'h00777, 1);
      issue(2'b10, 19'h00777, 19'h0, 1);
      wait_drain();

      // Flush in IDLE, then underflow, pc wrap and reserved opcode
      @(negedge clk);
      flush_now();
      issue(2'b10, 19'h7FFFF, 19'h0, 1);
      issue(2'b11, 19'h00400, 19'h0, 1);
      issue(2'b00, 19'h7FFFF, 19'h0, 1);
      wait_drain();

      // Backpressure
      rmode = 1;
      issue(2'b01, 19'h00500, 19'h06000, 1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(res_valid), 32'd1);
         @(negedge clk);
      end
      rmode = 2;
      wait_drain();

      // Flush while the RET read is in flight
      for (int i = 0; i < 3; i++) issue(2'b01, 19'(16'h100 * (i + 1)), 19'h0, 1);
      wait_drain();
      issue(2'b10, 19'h0, 19'h0, 0);
      chk("in_ret_rd_valid", 32'(res_valid), 32'd0);
      flush_now();

      // Randomized mix with random backpressure
      rmode = 0;
      for (int i = 0; i < 400; i++) begin
         int unsigned r = $urandom_range(0, 99);
         logic [1:0]  oc;
         logic [18:0] pc;
         oc = (r < 45) ? 2'b01 : (r < 85) ? 2'b10 : (r < 95) ? 2'b00 : 2'b11;
         pc = ($urandom_range(0, 15) == 0) ? 19'h7FFFF : 19'($urandom);
         issue(oc, pc, 19'($urandom), 1);
      end
      rmode = 2;
      wait_drain();

      // Reset during RESP
      rmode = 1;
      issue(2'b01, 19'h00900, 19'h0A000, 0);
      chk("pre_rst_valid", 32'(res_valid), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", 32'(res_valid), 32'd0);
      chk("mid_rst_pc", 32'(res_pc), 32'd0);
      chk("mid_rst_sp", 32'(res_sp), 32'hFF);
      chk("mid_rst_err", 32'(res_err), 32'd0);
      chk("mid_rst_depth", 32'(depth), 32'd0);
      mstk.delete();
      rst_n = 1'b1;
      rmode = 2;
      issue(2'b10, 19'h00020, 19'h0, 1);
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
